hs32_mem_arb: RTL
=================

HS32_MEM_ARB -- requirements
Module: hs32_mem_arb

Interface
REQ-001 SHALL have parameter TMO_CYC, default 255, meaning the memory-ack timeout in cycles; 0 disables the timeout.
REQ-002 SHALL have port clk  input  1  the single 12 MHz clock; all logic is on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port f_reqm  input  1  fetch request, read-only.
REQ-005 SHALL have port f_addr  input  32  fetch address.
REQ-006 SHALL have port f_dtr  output  32  fetch read data.
REQ-007 SHALL have port f_ackm  output  1  fetch done, one-cycle pulse.
REQ-008 SHALL have port x_reqm  input  1  exec request.
REQ-009 SHALL have port x_addr  input  32  exec address.
REQ-010 SHALL have port x_rw  input  1  exec direction, 1 = write.
REQ-011 SHALL have port x_dtw  input  32  exec write data.
REQ-012 SHALL have port x_dtr  output  32  exec read data.
REQ-013 SHALL have port x_ackm  output  1  exec done, one-cycle pulse.
REQ-014 SHALL have port m_stb  output  1  memory strobe.
REQ-015 SHALL have port m_addr  output  32  memory address.
REQ-016 SHALL have port m_rw  output  1  memory direction, 1 = write.
REQ-017 SHALL have port m_dtw  output  32  memory write data.
REQ-018 SHALL have port m_dtr  input  32  memory read data.
REQ-019 SHALL have port m_ack  input  1  memory done.
REQ-020 SHALL have port m_owner  output  1  current grant, 1 = exec.
REQ-021 SHALL have port m_tmo  output  1  timeout flag, one-cycle pulse.

Function
REQ-022 SHALL implement an FSM with states IDLE, BUSY and RESP, and every output SHALL be registered.
REQ-023 Requester contract: reqm is held high with addr, rw and dtw stable until that requester's ackm pulse; reqm is dropped the cycle after ackm.
REQ-024 IDLE with no reqm: stay in IDLE and hold m_stb at 0.
REQ-025 IDLE with any reqm sampled at edge N: select a winner per REQ-026, latch its addr, rw and dtw (fetch forces rw=0, dtw=0), set m_owner, assert m_stb from cycle N+1, and enter BUSY.
REQ-026 Both reqm high in IDLE: exec wins (fixed priority), except as modified by REQ-036.
REQ-027 BUSY: hold m_stb, m_addr, m_rw and m_dtw stable; requests from the other port are ignored and stay pending.
REQ-028 BUSY with m_ack high at edge K: drop m_stb, capture m_dtr into the owner's dtr register (write cycles also capture it), pulse the owner's ackm for cycle K+1, and enter RESP.
REQ-029 RESP: lasts exactly 1 cycle, then IDLE; first re-arbitration happens at edge K+2, so back-to-back grants are spaced 3 cycles minimum.
REQ-030 The non-owner's dtr SHALL hold its previous value; ackm SHALL never be asserted to the non-owner.
REQ-031 Timeout counter: clears on BUSY entry and increments each BUSY cycle; if TMO_CYC!=0 and the count reaches TMO_CYC without m_ack, behave as REQ-028 with captured data forced to 0 and m_tmo pulsed together with ackm.
REQ-032 m_ack and timeout on the same edge: m_ack wins, no m_tmo, real data captured.
REQ-033 m_ack while in IDLE or RESP: ignored with no state change.

Reset
REQ-034 reset high at any edge, including mid-BUSY: state goes to IDLE, and m_stb, f_ackm, x_ackm, m_tmo, m_rw and m_owner go to 0; m_addr, m_dtw, f_dtr, x_dtr and the timeout counter go to 0; the last-served flag goes to fetch; an in-flight transfer is abandoned with no ackm.
REQ-035 The first arbitration after reset SHALL occur at the first edge with reset low.

Configuration
REQ-036 Macro HS32_ARB_RR_EN: when defined, a simultaneous request in IDLE is granted to the port not served last; the last-served flag updates on every RESP. When undefined, fixed exec priority applies and the flag logic is absent.

Verification
REQ-037 x_reqm with x_addr=0x100, x_rw=0 at edge 0, m_ack with m_dtr=0xDEADBEEF at edge 3 -> m_stb high cycles 1-3, x_dtr=0xDEADBEEF, x_ackm pulses in cycle 4, f_ackm stays 0.
REQ-038 f_reqm and x_reqm both held, m_ack 1 cycle after each strobe -> without the macro, exec is served repeatedly and fetch starves; with HS32_ARB_RR_EN, grants alternate exec, fetch, exec.
REQ-039 Exec write x_addr=0x20, x_dtw=0x12345678 -> m_rw=1, m_dtw=0x12345678, m_addr=0x20 held stable until m_ack.
REQ-040 TMO_CYC=4 and m_ack never asserted -> after 4 BUSY cycles, m_tmo and the owner's ackm pulse together, dtr=0, and the FSM returns to IDLE.
REQ-041 reset asserted in the second BUSY cycle -> the next cycle shows m_stb=0 with no ackm; after reset is released, the still-held reqm is re-granted.

Source files
------------

// File: rtl/hs32_mem_arb.sv
// rtl/hs32_mem_arb.sv - two-port (fetch/exec) memory arbiter with ack timeout; optional HS32_ARB_RR_EN round-robin
`timescale 1ns/1ps

module hs32_mem_arb #(
    parameter int unsigned TMO_CYC = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_reqm,
    input  logic [31:0] f_addr,
    output logic [31:0] f_dtr,
    output logic        f_ackm,
    input  logic        x_reqm,
    input  logic [31:0] x_addr,
    input  logic        x_rw,
    input  logic [31:0] x_dtw,
    output logic [31:0] x_dtr,
    output logic        x_ackm,
    output logic        m_stb,
    output logic [31:0] m_addr,
    output logic        m_rw,
    output logic [31:0] m_dtw,
    input  logic [31:0] m_dtr,
    input  logic        m_ack,
    output logic        m_owner,
    output logic        m_tmo
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    // Count value at which the current BUSY cycle is the last one allowed.
    localparam logic [31:0] TMO_LAST = 32'(TMO_CYC) - 32'd1;
    localparam bit          TMO_EN   = (TMO_CYC != 0);

    state_t      state, state_nxt;
    logic [31:0] tmo_cnt, tmo_cnt_nxt;
    logic        tmo_hit;
    logic        done;
    logic        prio_x;
    logic        grant_x;
    logic [31:0] rdata;

    logic        m_stb_nxt, m_rw_nxt, m_owner_nxt, m_tmo_nxt;
    logic        f_ackm_nxt, x_ackm_nxt;
    logic [31:0] m_addr_nxt, m_dtw_nxt, f_dtr_nxt, x_dtr_nxt;

    assign tmo_hit = TMO_EN && (tmo_cnt == TMO_LAST);
    assign done    = m_ack || tmo_hit;
    assign grant_x = x_reqm && (!f_reqm || prio_x);
    // A timeout returns zero data; a real ack always wins over a coincident timeout.
    assign rdata   = m_ack ? m_dtr : 32'd0;

`ifdef HS32_ARB_RR_EN
    logic last_x;

    // On a tie, exec wins only if fetch was served last.
    assign prio_x = !last_x;

    // Remember which port finished most recently.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_x <= 1'b0;
        end else if (state == RESP) begin
            last_x <= m_owner;
        end
    end
`else
    assign prio_x = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (f_reqm || x_reqm) state_nxt = BUSY;
            BUSY:    if (done)             state_nxt = RESP;
            RESP:                          state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    // Next values for every registered output and the timeout counter.
    always_comb begin
        m_stb_nxt   = m_stb;
        m_addr_nxt  = m_addr;
        m_rw_nxt    = m_rw;
        m_dtw_nxt   = m_dtw;
        m_owner_nxt = m_owner;
        f_dtr_nxt   = f_dtr;
        x_dtr_nxt   = x_dtr;
        f_ackm_nxt  = 1'b0;
        x_ackm_nxt  = 1'b0;
        m_tmo_nxt   = 1'b0;
        tmo_cnt_nxt = tmo_cnt;
        case (state)
            IDLE: begin
                if (f_reqm || x_reqm) begin
                    m_stb_nxt   = 1'b1;
                    m_owner_nxt = grant_x;
                    m_addr_nxt  = grant_x ? x_addr : f_addr;
                    m_rw_nxt    = grant_x && x_rw;
                    m_dtw_nxt   = grant_x ? x_dtw : 32'd0;
                    tmo_cnt_nxt = 32'd0;
                end
            end
            BUSY: begin
                if (done) begin
                    m_stb_nxt = 1'b0;
                    m_tmo_nxt = !m_ack;
                    if (m_owner) begin
                        x_dtr_nxt  = rdata;
                        x_ackm_nxt = 1'b1;
                    end else begin
                        f_dtr_nxt  = rdata;
                        f_ackm_nxt = 1'b1;
                    end
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 32'd1;
                end
            end
            default: begin
            end
        endcase
    end

    // Output and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_stb   <= 1'b0;
            m_addr  <= 32'd0;
            m_rw    <= 1'b0;
            m_dtw   <= 32'd0;
            m_owner <= 1'b0;
            f_dtr   <= 32'd0;
            x_dtr   <= 32'd0;
            f_ackm  <= 1'b0;
            x_ackm  <= 1'b0;
            m_tmo   <= 1'b0;
            tmo_cnt <= 32'd0;
        end else begin
            m_stb   <= m_stb_nxt;
            m_addr  <= m_addr_nxt;
            m_rw    <= m_rw_nxt;
            m_dtw   <= m_dtw_nxt;
            m_owner <= m_owner_nxt;
            f_dtr   <= f_dtr_nxt;
            x_dtr   <= x_dtr_nxt;
            f_ackm  <= f_ackm_nxt;
            x_ackm  <= x_ackm_nxt;
            m_tmo   <= m_tmo_nxt;
            tmo_cnt <= tmo_cnt_nxt;
        end
    end

endmodule
